// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target endpoint.
package spi_target_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = $clog2(BYTE_W);

  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchronizer for one asynchronous input, with level and
// single-cycle rise/fall strobes taken from the last two synced samples.
// Flops reset to 0 so that a chip select already held low when reset is
// released does not look like a new falling edge.
module spi_target_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  // Edge strobes from the current and previous synced sample
  always_comb begin
    level = chain[SYNC_STAGES-1];
    rise  = level & ~prev;
    fall  = ~level & prev;
  end

endmodule

// File: rtl/spi_target.sv
// SPI target (mode 0, MSB first) with byte-wide RX/TX holding registers.
// Optional build macro: SPI_TARGET_ERR_EN adds sticky ovr/udr flags and
// an err_clr input.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_empty,
  output logic              busy
`ifdef SPI_TARGET_ERR_EN
  ,
  input  logic              err_clr,
  output logic              ovr,
  output logic              udr
`endif
);

  state_t state, state_nxt;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-2:0] rx_shift;
  logic [BYTE_W-1:0] tx_shift;
  logic [BYTE_W-1:0] hold;
  logic              reload_pend;

  logic              start, stop, shift_in, byte_done, shift_out, reload, load;
  logic [BYTE_W-1:0] load_val;
  logic [BYTE_W-1:0] rx_byte;

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and bus-facing outputs; miso idles high when deselected
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    miso_oe   = 1'b0;
    miso      = 1'b1;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        busy    = 1'b1;
        miso_oe = 1'b1;
        miso    = tx_shift[BYTE_W-1];
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-cycle strobes; a deselect in the same cycle as an sclk edge wins
  always_comb begin
    start     = (state == IDLE) && cs_fall;
    stop      = (state == ACTIVE) && cs_rise;
    shift_in  = (state == ACTIVE) && !cs_rise && sclk_rise;
    byte_done = shift_in && (bit_cnt == CNT_W'(BYTE_W - 1));
    shift_out = (state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt != '0);
    reload    = (state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0) && reload_pend;
    load      = start || reload;
    load_val  = tx_empty ? IDLE_BYTE : hold;
    rx_byte   = {rx_shift, mosi_lvl};
  end

  // Bit counter and pending-reload flag for the byte boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
    end else if (start || stop) begin
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
    end else begin
      if (shift_in) bit_cnt <= bit_cnt + 1'b1;
      if (byte_done)   reload_pend <= 1'b1;
      else if (reload) reload_pend <= 1'b0;
    end
  end

  // Receive shift register and RX holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (shift_in)  rx_shift <= rx_byte[BYTE_W-2:0];
      if (byte_done) rx_data  <= rx_byte;
      if (byte_done)  rx_valid <= 1'b1;
      else if (rx_rd) rx_valid <= 1'b0;
    end
  end

  // Transmit shift register; a load samples holding before any same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (load) begin
      tx_shift <= load_val;
    end else if (shift_out) begin
      tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
    end
  end

  // TX holding register; a same-cycle write refills it after the load drains it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      tx_empty <= 1'b1;
    end else begin
      if (tx_wr) hold <= tx_data;
      if (tx_wr)     tx_empty <= 1'b0;
      else if (load) tx_empty <= 1'b1;
    end
  end

`ifdef SPI_TARGET_ERR_EN
  logic overrun, underrun;

  always_comb begin
    overrun  = byte_done && rx_valid && !rx_rd;
    underrun = load && tx_empty;
  end

  // Sticky error flags; a new event beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
      udr <= 1'b0;
    end else begin
      if (overrun)      ovr <= 1'b1;
      else if (err_clr) ovr <= 1'b0;
      if (underrun)     udr <= 1'b1;
      else if (err_clr) udr <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bench-side SPI master drives directed bytes while
// a transaction-level model tracks the host-visible registers.
module tb_spi_target;

  localparam int S  = 2;
  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, miso, miso_oe, rx_valid, rx_rd;
  logic       tx_wr, tx_empty, busy;
  logic [7:0] rx_data, tx_data;
`ifdef SPI_TARGET_ERR_EN
  logic       err_clr, ovr, udr;
`endif

  always #5 clk = ~clk;

  spi_target #(.SYNC_STAGES(S), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_rd(rx_rd), .tx_data(tx_data), .tx_wr(tx_wr), .tx_empty(tx_empty),
    .busy(busy)
`ifdef SPI_TARGET_ERR_EN
    , .err_clr(err_clr), .ovr(ovr), .udr(udr)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Transaction-level model
  bit         m_busy, m_rx_valid, m_hold_v, m_ovr, m_udr;
  logic [7:0] m_rx_data, m_hold, m_cur;
  bit         chk_en = 1'b0;

  function automatic void chk8(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_rx_valid = 0; m_hold_v = 0; m_ovr = 0; m_udr = 0;
    m_rx_data = 8'h00; m_hold = 8'h00; m_cur = 8'h00;
  endfunction

  function automatic logic [7:0] m_load();
    if (m_hold_v) begin
      m_hold_v = 0;
      return m_hold;
    end
    m_udr = 1;
    return 8'hFF;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("busy", busy, m_busy);
      chk1("miso_oe", miso_oe, m_busy);
      chk1("miso", miso, m_busy ? m_cur[7] : 1'b1);
      chk1("rx_valid", rx_valid, m_rx_valid);
      chk8("rx_data", rx_data, m_rx_data);
      chk1("tx_empty", tx_empty, !m_hold_v);
`ifdef SPI_TARGET_ERR_EN
      chk1("ovr", ovr, m_ovr);
      chk1("udr", udr, m_udr);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic quiet(input int n);
    tick(S + 2);
    chk_en = 1'b1;
    tick(n);
    chk_en = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] v);
    tx_data = v; tx_wr = 1'b1;
    tick(1);
    tx_wr = 1'b0;
    m_hold = v; m_hold_v = 1;
  endtask

  task automatic read_rx();
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
    m_rx_valid = 0;
    quiet(2);
  endtask

  task automatic clear_err();
`ifdef SPI_TARGET_ERR_EN
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
`endif
    m_ovr = 0; m_udr = 0;
    quiet(2);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    m_cur = m_load();
    m_busy = 1;
    quiet(2);
  endtask

  task automatic cs_high();
    tick(HP);
    cs_n = 1'b1;
    m_busy = 0;
    quiet(3);
  endtask

  // One full byte; optional rx_rd on the completion cycle and tx_wr on the reload cycle
  task automatic xfer(input logic [7:0] mo, input bit rd_at_done, input bit wr_at_reload,
                      input logic [7:0] wv, output logic [7:0] mi);
    logic [7:0] got;
    logic [7:0] exp;
    exp = m_cur;
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      tick(HP);
      got[i] = miso;
      sclk = 1'b1;
      if (i == 0 && rd_at_done) begin
        tick(S); rx_rd = 1'b1; tick(1); rx_rd = 1'b0; tick(HP - S - 1);
      end else begin
        tick(HP);
      end
      sclk = 1'b0;
      if (i == 0 && wr_at_reload) begin
        tick(S); tx_data = wv; tx_wr = 1'b1; tick(1); tx_wr = 1'b0; tick(HP - S - 1);
      end
    end
    if (m_rx_valid && !rd_at_done) m_ovr = 1;
    m_rx_data = mo;
    m_rx_valid = 1;
    m_cur = m_load();
    if (wr_at_reload) begin
      m_hold = wv; m_hold_v = 1;
    end
    chk8("miso_byte", got, exp);
    mi = got;
  endtask

  task automatic partial(input logic [7:0] mo, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7 - i];
      tick(HP);
      sclk = 1'b1;
      tick(HP);
      sclk = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rx_rd = 1'b0; tx_wr = 1'b0; tx_data = 8'h00;
`ifdef SPI_TARGET_ERR_EN
    err_clr = 1'b0;
`endif
    m_reset();
    tick(3);
    chk1("rst_miso", miso, 1'b1);
    chk1("rst_miso_oe", miso_oe, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_tx_empty", tx_empty, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    quiet(3);

    // Loaded TX byte goes out while 3C comes in
    write_tx(8'hA5);
    quiet(2);
    cs_low();
    xfer(8'h3C, 0, 0, 8'h00, mi);
    chk8("t1_miso_lit", mi, 8'hA5);
    cs_high();
    chk8("t1_rx_lit", rx_data, 8'h3C);
    chk1("t1_valid_lit", rx_valid, 1'b1);
    chk1("t1_empty_lit", tx_empty, 1'b1);
    read_rx();
    clear_err();

    // Empty holding register sends the idle byte
    cs_low();
    xfer(8'h00, 0, 0, 8'h00, mi);
    chk8("t2_miso_lit", mi, 8'hFF);
    cs_high();
`ifdef SPI_TARGET_ERR_EN
    chk1("t2_udr_lit", udr, 1'b1);
`endif
    clear_err();
`ifdef SPI_TARGET_ERR_EN
    chk1("t2_udr_clr_lit", udr, 1'b0);
`endif
    read_rx();

    // Back-to-back bytes without reading: overrun
    cs_low();
    xfer(8'h11, 0, 0, 8'h00, mi);
    xfer(8'h22, 0, 0, 8'h00, mi);
    cs_high();
    chk8("t3_rx_lit", rx_data, 8'h22);
    chk1("t3_valid_lit", rx_valid, 1'b1);
`ifdef SPI_TARGET_ERR_EN
    chk1("t3_ovr_lit", ovr, 1'b1);
`endif
    read_rx();
    clear_err();

    // Aborted partial byte leaves no trace, then a full byte
    cs_low();
    partial(8'hFF, 5);
    cs_high();
    chk1("t4_nospur_lit", rx_valid, 1'b0);
    cs_low();
    xfer(8'h81, 0, 0, 8'h00, mi);
    cs_high();
    chk8("t4_rx_lit", rx_data, 8'h81);
`ifdef SPI_TARGET_ERR_EN
    chk1("t4_ovr_lit", ovr, 1'b0);
`endif
    read_rx();
    clear_err();

    // Overwrite before select; write in reload cycle waits a byte; read at completion
    write_tx(8'h5A);
    write_tx(8'hC3);
    quiet(2);
    cs_low();
    xfer(8'h0F, 0, 1, 8'h69, mi);
    chk8("t5_b1_lit", mi, 8'hC3);
    chk1("t5_held_lit", tx_empty, 1'b0);
    xfer(8'hF0, 1, 0, 8'h00, mi);
    chk8("t5_b2_lit", mi, 8'hFF);
    quiet(2);
    chk8("t5_rx2_lit", rx_data, 8'hF0);
    chk1("t5_valid2_lit", rx_valid, 1'b1);
`ifdef SPI_TARGET_ERR_EN
    chk1("t5_noovr_lit", ovr, 1'b0);
`endif
    xfer(8'h3A, 0, 0, 8'h00, mi);
    chk8("t5_b3_lit", mi, 8'h69);
    cs_high();
`ifdef SPI_TARGET_ERR_EN
    chk1("t5_ovr_lit", ovr, 1'b1);
`endif
    read_rx();
    clear_err();

    // Reset in the middle of a byte, cs_n still low afterwards
    write_tx(8'hE7);
    cs_low();
    partial(8'hAA, 3);
    mosi = 1'b1;
    tick(HP);
    sclk = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    chk1("t6_miso_lit", miso, 1'b1);
    chk1("t6_oe_lit", miso_oe, 1'b0);
    chk8("t6_rx_lit", rx_data, 8'h00);
    chk1("t6_valid_lit", rx_valid, 1'b0);
    chk1("t6_empty_lit", tx_empty, 1'b1);
    chk1("t6_busy_lit", busy, 1'b0);
`ifdef SPI_TARGET_ERR_EN
    chk1("t6_ovr_lit", ovr, 1'b0);
    chk1("t6_udr_lit", udr, 1'b0);
`endif
    m_reset();
    tick(2);
    sclk = 1'b0;
    rst = 1'b0;
    quiet(4);
    cs_n = 1'b1;
    quiet(3);
    write_tx(8'h4B);
    cs_low();
    xfer(8'hD2, 0, 0, 8'h00, mi);
    chk8("t6_miso_lit2", mi, 8'h4B);
    cs_high();
    chk8("t6_rx_lit2", rx_data, 8'hD2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
